ts_packet_arbiter: RTL and testbench
====================================

# ts_packet_arbiter

Packet-aligned weighted round-robin scheduler for the four-channel MPEG2-TS input mux. It decides which of four transport-stream channels drives the mux select (`mux_ctrl`) and moves exactly one 188-byte packet per grant into the downstream FIFO. It pops bytes from the granted channel and honours FIFO backpressure. Each channel's QoS weight sets how many consecutive packets it may send per turn.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width of channel and mux data.
- `PKT_LEN`, 188: TS packet length in bytes; byte counter width is `$clog2(PKT_LEN)`.
- `SYNC_BYTE`, 8'h47: expected first byte of every packet.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ch_pkt_ready`  in  4: bit i high means channel i holds at least one complete packet.
- `weight`  in  8: 2 bits per channel (`[2i+1:2i]`); credit = weight + 1 packets per turn (1..4).
- `mux_data`  in  DATA_WIDTH: mux output, used only for the sync check.
- `fifo_full`  in  1: downstream FIFO cannot accept a write this cycle.
- `mux_ctrl`  out  2: registered select to the mux, equal to the granted channel index.
- `ch_rd_en`  out  4: one-hot byte pop to the granted channel.
- `fifo_wr_en`  out  1: write `mux_data` into the FIFO this cycle.
- `pkt_start`  out  1: one-cycle pulse in the GRANT cycle.
- `pkt_end`  out  1: one-cycle pulse coincident with the last byte write.
- `sync_err`  out  1: one-cycle pulse coincident with a first-byte write that is not `SYNC_BYTE`.
- `busy`  out  1: high in GRANT and XFER.

## Operation
- Channels are first-word-fall-through: data is valid on `mux_data` while selected, and `ch_rd_en` advances the channel to its next byte.
- FSM states:
  - **ARB**, the reset state. Evaluated every cycle.
    - If `credit > 0` and `ch_pkt_ready[cur]`, re-grant `cur` without a credit reload.
    - Otherwise search from `cur+1` modulo 4 for the first ready channel, set `cur` to it, and load `credit = weight[cur] + 1`.
    - If a channel is granted, go to GRANT. If none is ready, stay in ARB and clear `credit` to 0.
  - **GRANT**, one cycle. `mux_ctrl = cur`, `pkt_start` = 1, byte_cnt = 0. Go to XFER.
  - **XFER**:
    - Each cycle with `fifo_full` = 0: `ch_rd_en[cur]` = 1, `fifo_wr_en` = 1, byte_cnt++.
    - Each cycle with `fifo_full` = 1: both enables are 0 and byte_cnt holds.
    - The write at byte_cnt == PKT_LEN-1 pulses `pkt_end`, decrements `credit`, and returns the FSM to ARB.
- Sync check: on the write at byte_cnt == 0, if `mux_data != SYNC_BYTE`, pulse `sync_err`. The packet still transfers in full, with exactly PKT_LEN bytes and no resync.
- `weight` is sampled only at credit reload. Changes made mid-turn take effect at the next reload.
- `ch_pkt_ready` is ignored outside ARB. Deasserting it mid-packet does not abort the transfer.
- Reset state:
  - `mux_ctrl` = 0, all pulses and enables = 0, `busy` = 0.
  - `cur` = 3, so the first search starts at channel 0.
  - `credit` = 0, byte_cnt = 0.
- Reset mid-packet abandons the packet at the next edge. No further `ch_rd_en` or `fifo_wr_en` is issued. Draining the partial packet is the upstream's responsibility.
- `mux_ctrl` changes only in the ARB→GRANT transition, never during XFER.

## Timing
- Arbitration decision is made in the ARB cycle and is registered. `mux_ctrl` is updated at the start of GRANT, so one full cycle of settling precedes the first write.
- With no stalls, a packet occupies 1 ARB + 1 GRANT + PKT_LEN XFER cycles: 190 cycles for PKT_LEN = 188.
- `fifo_full` acts combinationally on `ch_rd_en` and `fifo_wr_en` in the same cycle. Each stall cycle adds exactly one cycle.
- `pkt_start`, `pkt_end` and `sync_err` are never longer than one cycle. `pkt_end` and `pkt_start` can never coincide.
- `busy` = 1 from GRANT through the `pkt_end` cycle inclusive.

## Test plan
- Only `ch_pkt_ready` = 0010, weight = 0, no stalls → `mux_ctrl` = 01 from cycle 2; 188 consecutive `ch_rd_en` = 0010 / `fifo_wr_en`; `pkt_end` on the 188th write; next `pkt_start` 190 cycles after the first.
- All ready, weight = 0 → grant order 0,1,2,3,0,1 with one packet each; `mux_ctrl` constant within each packet.
- All ready, weight = 8'h02 (channel 0 credit 3) → grant order 0,0,0,1,2,3,0,0,0; a `weight` change mid-turn is applied only at the next channel-0 reload.
- `fifo_full` high for 10 cycles at byte 50 → enables low for those 10 cycles; byte_cnt holds at 50; exactly 188 writes; XFER lasts 198 cycles.
- First byte 8'h00, all other bytes valid → `sync_err` pulses once, coincident with the first write; 188 bytes transferred; `pkt_end` asserted normally.
- `rst` at byte 100 of channel 2, all channels ready → next cycle all outputs are 0; the first grant after reset goes to channel 0 with a fresh credit load.

Source files
------------

// File: rtl/ts_packet_arbiter_if.sv
// rtl/ts_packet_arbiter_if.sv - channel/FIFO signal bundle for the four-channel TS packet arbiter
interface ts_packet_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [3:0]            ch_pkt_ready;
    logic [7:0]            weight;
    logic [DATA_WIDTH-1:0] mux_data;
    logic                  fifo_full;
    logic [1:0]            mux_ctrl;
    logic [3:0]            ch_rd_en;
    logic                  fifo_wr_en;
    logic                  pkt_start;
    logic                  pkt_end;
    logic                  sync_err;
    logic                  busy;

    modport master (
        input  ch_pkt_ready, weight, mux_data, fifo_full,
        output mux_ctrl, ch_rd_en, fifo_wr_en, pkt_start, pkt_end, sync_err, busy
    );

    modport slave (
        output ch_pkt_ready, weight, mux_data, fifo_full,
        input  mux_ctrl, ch_rd_en, fifo_wr_en, pkt_start, pkt_end, sync_err, busy
    );
endinterface

// File: rtl/ts_packet_arbiter.sv
// rtl/ts_packet_arbiter.sv - packet-aligned weighted round-robin scheduler for the 4-channel TS mux
module ts_packet_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h47
) (
    input logic                 clk,
    input logic                 rst,
    ts_packet_arbiter_if.master bus
);
    localparam int CW = $clog2(PKT_LEN);

    typedef enum logic [1:0] {ARB = 2'd0, GRANT = 2'd1, XFER = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cur_q, cur_d;
    logic [1:0]    mux_ctrl_q, mux_ctrl_d;
    logic [2:0]    credit_q, credit_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;

    logic       grant_found;
    logic       grant_reload;
    logic [1:0] grant_ch;
    logic [1:0] cand;
    logic [1:0] weight_sel;
    logic       wr;
    logic       last_byte;

    // Keep granting the current channel while it has credit; otherwise scan
    // cur+1..cur+4 so the current channel is considered last.
    always_comb begin
        grant_found  = 1'b0;
        grant_reload = 1'b0;
        grant_ch     = cur_q;
        cand         = cur_q;
        if (credit_q != 3'd0 && bus.ch_pkt_ready[cur_q]) begin
            grant_found = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand = cur_q + 2'(k);
                if (!grant_found && bus.ch_pkt_ready[cand]) begin
                    grant_found  = 1'b1;
                    grant_reload = 1'b1;
                    grant_ch     = cand;
                end
            end
        end
        weight_sel = bus.weight[{grant_ch, 1'b0} +: 2];
    end

    assign wr        = (state_q == XFER) && !bus.fifo_full;
    assign last_byte = (byte_cnt_q == CW'(PKT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            cur_q      <= 2'd3;
            mux_ctrl_q <= 2'd0;
            credit_q   <= 3'd0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            mux_ctrl_q <= mux_ctrl_d;
            credit_q   <= credit_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        mux_ctrl_d = mux_ctrl_q;
        credit_d   = credit_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            ARB: begin
                if (grant_found) begin
                    state_d    = GRANT;
                    cur_d      = grant_ch;
                    mux_ctrl_d = grant_ch;
                    if (grant_reload) begin
                        credit_d = 3'(weight_sel) + 3'd1;
                    end
                end else begin
                    credit_d = 3'd0;
                end
            end
            GRANT: begin
                byte_cnt_d = '0;
                state_d    = XFER;
            end
            XFER: begin
                if (wr) begin
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        credit_d   = credit_q - 3'd1;
                        state_d    = ARB;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        bus.mux_ctrl   = mux_ctrl_q;
        bus.pkt_start  = (state_q == GRANT);
        bus.busy       = (state_q != ARB);
        bus.fifo_wr_en = wr;
        bus.ch_rd_en   = wr ? (4'b0001 << mux_ctrl_q) : 4'b0000;
        bus.pkt_end    = wr && last_byte;
        bus.sync_err   = wr && (byte_cnt_q == '0) && (bus.mux_data != SYNC_BYTE);
    end
endmodule

// File: tb/tb_ts_packet_arbiter.sv
// tb/tb_ts_packet_arbiter.sv - packet-level vector table plus reset sequence for ts_packet_arbiter
module tb_ts_packet_arbiter;
    localparam int PKT_LEN = 188;

    typedef struct {
        logic [3:0] ready;
        logic [7:0] weight;
        int         stall_at;
        int         stall_len;
        logic [7:0] first_byte;
        int         exp_ch;
        int         exp_sync;
        int         gap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] first_byte = 8'h47;
    int         ptr [4];
    int         tests = 0;
    int         fails = 0;
    vec_t       vecs [17];

    ts_packet_arbiter_if #(.DATA_WIDTH(8)) bus ();

    ts_packet_arbiter #(.DATA_WIDTH(8), .PKT_LEN(PKT_LEN), .SYNC_BYTE(8'h47)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // First-word-fall-through channel model: byte index advances on each pop
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) ptr[i] <= 0;
            else if (bus.ch_rd_en[i]) ptr[i] <= (ptr[i] == PKT_LEN - 1) ? 0 : ptr[i] + 1;
        end
    end

    always_comb begin
        bus.mux_data = (ptr[bus.mux_ctrl] == 0) ? first_byte : (8'(ptr[bus.mux_ctrl]) | 8'h80);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic ff);
        @(negedge clk);
        bus.fifo_full = ff;
        #1;
    endtask

    task automatic run_packet(input int idx, input vec_t v);
        int   t, wr, xc, scnt, stall_left;
        bit   bad_en, bad_mc, bad_busy, bad_sync, bad_end, seen_end;
        logic ff;
        bus.ch_pkt_ready = v.ready;
        bus.weight       = v.weight;
        first_byte       = v.first_byte;
        t = 0;
        do begin
            step(1'b0);
            t++;
        end while (!bus.pkt_start && t < 400);
        check($sformatf("v%0d_start_seen", idx), bus.pkt_start, 1);
        if (bus.pkt_start !== 1'b1) return;
        if (v.gap >= 0) check($sformatf("v%0d_arb_gap", idx), t, v.gap);
        check($sformatf("v%0d_grant_ch", idx), bus.mux_ctrl, v.exp_ch);
        check($sformatf("v%0d_grant_busy", idx), bus.busy, 1);
        wr = 0; xc = 0; scnt = 0; stall_left = v.stall_len;
        bad_en = 0; bad_mc = 0; bad_busy = 0; bad_sync = 0; bad_end = 0; seen_end = 0;
        while (!seen_end && xc < 600) begin
            ff = (wr == v.stall_at) && (stall_left > 0);
            if (ff) stall_left--;
            step(ff);
            xc++;
            if (bus.fifo_wr_en !== !ff) bad_en = 1;
            if (bus.ch_rd_en !== (bus.fifo_wr_en ? 4'(1 << v.exp_ch) : 4'b0)) bad_en = 1;
            if (bus.mux_ctrl !== 2'(v.exp_ch)) bad_mc = 1;
            if (bus.busy !== 1'b1 || bus.pkt_start !== 1'b0) bad_busy = 1;
            if (bus.sync_err === 1'b1) begin
                scnt++;
                if (!(bus.fifo_wr_en === 1'b1 && wr == 0)) bad_sync = 1;
            end
            if (bus.pkt_end === 1'b1) begin
                seen_end = 1;
                if (!(bus.fifo_wr_en === 1'b1 && wr == PKT_LEN - 1)) bad_end = 1;
            end
            if (bus.fifo_wr_en === 1'b1) wr++;
        end
        bus.fifo_full = 1'b0;
        check($sformatf("v%0d_end_seen", idx), seen_end, 1);
        check($sformatf("v%0d_writes", idx), wr, PKT_LEN);
        check($sformatf("v%0d_xfer_cycles", idx), xc, PKT_LEN + v.stall_len);
        check($sformatf("v%0d_sync_errs", idx), scnt, v.exp_sync);
        check($sformatf("v%0d_enable_pattern", idx), {bad_en, bad_mc, bad_busy, bad_sync, bad_end}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr;
        vecs[0]  = '{4'b0010, 8'h00, -1,  0, 8'h47, 1, 0, 1};
        vecs[1]  = '{4'b0010, 8'h00, 50, 10, 8'h47, 1, 0, 2};
        vecs[2]  = '{4'b1111, 8'h00, -1,  0, 8'h00, 2, 1, 2};
        vecs[3]  = '{4'b1111, 8'h00, -1,  0, 8'h47, 3, 0, 2};
        vecs[4]  = '{4'b1111, 8'h00, -1,  0, 8'h47, 0, 0, 2};
        vecs[5]  = '{4'b1111, 8'h00, -1,  0, 8'h47, 1, 0, 2};
        vecs[6]  = '{4'b1111, 8'h02, -1,  0, 8'h47, 2, 0, 2};
        vecs[7]  = '{4'b1111, 8'h02, -1,  0, 8'h47, 3, 0, 2};
        vecs[8]  = '{4'b1111, 8'h02, -1,  0, 8'h47, 0, 0, 2};
        vecs[9]  = '{4'b1111, 8'h00, -1,  0, 8'h47, 0, 0, 2};
        vecs[10] = '{4'b1111, 8'h00, -1,  0, 8'h47, 0, 0, 2};
        vecs[11] = '{4'b1111, 8'h00, -1,  0, 8'h47, 1, 0, 2};
        vecs[12] = '{4'b1111, 8'h00, -1,  0, 8'h47, 2, 0, 2};
        vecs[13] = '{4'b1111, 8'h00, -1,  0, 8'h47, 3, 0, 2};
        vecs[14] = '{4'b1111, 8'h00, -1,  0, 8'h47, 0, 0, 2};
        vecs[15] = '{4'b1111, 8'h00, -1,  0, 8'h47, 1, 0, 2};
        vecs[16] = '{4'b0010, 8'h00, -1,  0, 8'h47, 1, 0, 2};

        bus.ch_pkt_ready = 4'b0000;
        bus.weight       = 8'h00;
        bus.fifo_full    = 1'b0;
        rst = 1'b1;
        repeat (3) step(1'b0);
        check("reset_outputs",
              {bus.mux_ctrl, bus.ch_rd_en, bus.fifo_wr_en, bus.pkt_start, bus.pkt_end, bus.sync_err, bus.busy}, 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_packet(i, vecs[i]);

        // Reset in the middle of a channel-2 packet, then a fresh credit load on channel 0
        bus.ch_pkt_ready = 4'b1111;
        bus.weight       = 8'h00;
        first_byte       = 8'h47;
        wr = 0;
        for (int t = 0; t < 400 && bus.pkt_start !== 1'b1; t++) step(1'b0);
        check("rst_seq_grant_ch", bus.mux_ctrl, 2);
        for (int t = 0; t < 400 && wr < 100; t++) begin
            step(1'b0);
            if (bus.fifo_wr_en === 1'b1) wr++;
        end
        check("rst_seq_writes_before", wr, 100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(1'b0);
        check("rst_mid_outputs",
              {bus.mux_ctrl, bus.ch_rd_en, bus.fifo_wr_en, bus.pkt_start, bus.pkt_end, bus.sync_err, bus.busy}, 0);
        step(1'b0);
        check("rst_hold_outputs",
              {bus.mux_ctrl, bus.ch_rd_en, bus.fifo_wr_en, bus.pkt_start, bus.pkt_end, bus.sync_err, bus.busy}, 0);
        rst = 1'b0;
        run_packet(17, '{4'b1111, 8'h01, -1, 0, 8'h47, 0, 0, 1});
        run_packet(18, '{4'b1111, 8'h01, -1, 0, 8'h47, 0, 0, 2});
        run_packet(19, '{4'b1111, 8'h01, -1, 0, 8'h47, 1, 0, 2});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
